// File: rtl/sync_hs_rx_ctrl_pkg.sv
// Shared types for the req/ack bundled-data receive controller.
// Holds the FSM state encoding and the default req synchronizer depth.
package sync_hs_rx_ctrl_pkg;

    localparam int unsigned SYNC_STAGES_DEF = 3;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        VALID = 2'd2,
        ACK   = 2'd3
    } state_e;

endpackage

// File: rtl/sync_bit_sreset.sv
// Single-bit multi-flop synchronizer with synchronous active-high clear.
// The last flop of the chain is the only safe consumer-side output.
module sync_bit_sreset
    import sync_hs_rx_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (clr) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/sync_hs_rx_ctrl.sv
// Destination side of a 4-phase req/ack bundled-data crossing.
// Captures the word on synchronized req, offers it valid/ready, then acks.
module sync_hs_rx_ctrl
    import sync_hs_rx_ctrl_pkg::*;
#(
    parameter int unsigned DW          = 32,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             async_req,
    input  logic [DW-1:0]    async_data,
    output logic             async_ack,
    output logic             out_pvld,
    input  logic             out_prdy,
    output logic [DW-1:0]    out_pd,
    input  logic             err_clr,
    output logic             err_sticky,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic             busy
);

    localparam int unsigned IW = $clog2(SYNC_STAGES + 1);
    localparam logic [IW-1:0] INIT_LAST = IW'(SYNC_STAGES);

    logic             sync_req;
    state_e           state;
    state_e           state_nx;
    logic [IW-1:0]    init_cnt;
    logic             load;
    logic             err_set;
    logic             cnt_inc;
    logic             ack_q;
    logic             pvld_q;
    logic             busy_q;
    logic             err_q;
    logic [DW-1:0]    pd_q;
    logic [CNT_W-1:0] cnt_q;

    sync_bit_sreset #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_req_sync (
        .clk(clk),
        .clr(clr),
        .d  (async_req),
        .q  (sync_req)
    );

    // ack/pvld/busy are flops so nothing glitches back across the crossing
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= INIT;
            init_cnt <= '0;
            ack_q    <= 1'b0;
            pvld_q   <= 1'b0;
            busy_q   <= 1'b1;
            err_q    <= 1'b0;
            pd_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state  <= state_nx;
            ack_q  <= (state_nx == ACK);
            pvld_q <= (state_nx == VALID);
            busy_q <= (state_nx != IDLE);
            if (state == INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
            if (load) begin
                pd_q <= async_data;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
            if (cnt_inc) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            INIT:    if (init_cnt == INIT_LAST) state_nx = sync_req ? ACK : IDLE;
            IDLE:    if (sync_req) state_nx = VALID;
            VALID:   if (pvld_q && out_prdy) state_nx = ACK;
            ACK:     if (!sync_req) state_nx = IDLE;
            default: state_nx = INIT;
        endcase
    end

    // a req still high once the chain has flushed predates reset: ack and drop it
    always_comb begin
        load    = 1'b0;
        err_set = 1'b0;
        cnt_inc = 1'b0;
        unique case (1'b1)
            state == INIT: err_set = (state_nx == ACK);
            state == IDLE: load = sync_req;
            state == VALID: begin
                err_set = !sync_req;
                cnt_inc = pvld_q && out_prdy;
            end
            default: ;
        endcase
    end

    assign async_ack  = ack_q;
    assign out_pvld   = pvld_q;
    assign out_pd     = pd_q;
    assign err_sticky = err_q;
    assign xfer_cnt   = cnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sync_hs_rx_ctrl.sv
// Bench for sync_hs_rx_ctrl: transaction-level reference model,
// per-cycle output compare, in-order scoreboard, directed + random traffic.
module tb_sync_hs_rx_ctrl;

    localparam int DW = 32;
    localparam int SS = 3;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          clr;
    logic          async_req;
    logic [DW-1:0] async_data;
    logic          async_ack;
    logic          out_pvld;
    logic          out_prdy;
    logic [DW-1:0] out_pd;
    logic          err_clr;
    logic          err_sticky;
    logic [CW-1:0] xfer_cnt;
    logic          busy;

    always #5 clk = ~clk;

    sync_hs_rx_ctrl #(
        .DW(DW),
        .SYNC_STAGES(SS),
        .CNT_W(CW)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .async_req (async_req),
        .async_data(async_data),
        .async_ack (async_ack),
        .out_pvld  (out_pvld),
        .out_prdy  (out_prdy),
        .out_pd    (out_pd),
        .err_clr   (err_clr),
        .err_sticky(err_sticky),
        .xfer_cnt  (xfer_cnt),
        .busy      (busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: req history queue, pending-word / ack flags,
    // flush countdown after reset.
    bit            mh [SS];
    bit            m_live = 1'b0;
    bit            m_init;
    int            m_left;
    bit            m_pvld;
    bit            m_ack;
    bit            m_err;
    logic [DW-1:0] m_pd;
    logic [CW-1:0] m_cnt;
    bit            preload = 1'b0;

    always @(posedge clk) begin : model
        bit s;
        bit seterr;
        s      = mh[SS-1];
        seterr = 1'b0;
        if (clr) begin
            m_live = 1'b1;
            m_init = 1'b1;
            m_left = SS;
            m_pvld = 1'b0;
            m_ack  = 1'b0;
            m_err  = 1'b0;
            m_pd   = '0;
            m_cnt  = '0;
        end else begin
            if (m_init) begin
                if (m_left == 0) begin
                    m_init = 1'b0;
                    if (s) begin
                        m_ack  = 1'b1;
                        seterr = 1'b1;
                    end
                end else begin
                    m_left--;
                end
            end else if (m_ack) begin
                if (!s) m_ack = 1'b0;
            end else if (m_pvld) begin
                if (!s) seterr = 1'b1;
                if (out_prdy) begin
                    m_pvld = 1'b0;
                    m_ack  = 1'b1;
                    m_cnt  = m_cnt + 1'b1;
                end
            end else if (s) begin
                m_pvld = 1'b1;
                m_pd   = async_data;
            end
            if (seterr) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
        if (preload) m_cnt = 16'hFFFF;
        for (int i = SS - 1; i > 0; i--) mh[i] = clr ? 1'b0 : mh[i-1];
        mh[0] = clr ? 1'b0 : async_req;
    end

    logic [DW-1:0] sb [$];
    int            delivered = 0;
    int            pv_cnt    = 0;

    always @(negedge clk) begin
        if (m_live) begin
            chk("ack", 32'(async_ack), 32'(m_ack));
            chk("pvld", 32'(out_pvld), 32'(m_pvld));
            chk("pd", out_pd, m_pd);
            chk("err", 32'(err_sticky), 32'(m_err));
            chk("cnt", 32'(xfer_cnt), 32'(m_cnt));
            chk("busy", 32'(busy), 32'(m_init | m_pvld | m_ack));
            if (out_pvld) pv_cnt++;
            if (out_pvld && out_prdy) begin
                delivered++;
                if (sb.size() != 0) chk("sb_word", out_pd, sb.pop_front());
                else chk("sb_size", 32'(sb.size()), 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sel 0 watches async_ack, sel 1 watches out_pvld; n = edges waited
    task automatic wait_for(input string nm, input int sel,
                            input logic lvl, output int n);
        logic v;
        n = 0;
        do begin
            tick();
            n++;
            v = (sel == 0) ? async_ack : out_pvld;
        end while (v !== lvl && n < 100);
        if (v !== lvl) chk(nm, 32'(v), 32'(lvl));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    bit done = 1'b0;

    initial begin : main
        int n;
        int pv0;
        int d0;
        logic [DW-1:0] w;

        clr        = 1'b1;
        async_req  = 1'b0;
        async_data = '0;
        out_prdy   = 1'b0;
        err_clr    = 1'b0;

        // reset release and chain flush
        repeat (2) tick();
        clr = 1'b0;
        repeat (3) tick();
        chk("init_busy", 32'(busy), 1);
        chk("init_pvld", 32'(out_pvld), 0);
        chk("init_ack", 32'(async_ack), 0);
        chk("init_cnt", 32'(xfer_cnt), 0);
        tick();
        chk("idle_busy", 32'(busy), 0);
        chk("idle_pd", out_pd, 0);

        // single transfer with ready high
        out_prdy   = 1'b1;
        async_data = 32'hDEADBEEF;
        sb.push_back(async_data);
        async_req  = 1'b1;
        wait_for("pvld_rise", 1, 1'b1, n);
        chk("pvld_lat", 32'(n), SS + 1);
        chk("pd_lit", out_pd, 32'hDEADBEEF);
        wait_for("ack_rise", 0, 1'b1, n);
        chk("ack_lat", 32'(n), 1);
        chk("pvld_drop", 32'(out_pvld), 0);
        async_req = 1'b0;
        wait_for("ack_fall", 0, 1'b0, n);
        chk("ackfall_lat", 32'(n), SS + 1);
        chk("cnt_one", 32'(xfer_cnt), 1);

        // backpressure
        out_prdy   = 1'b0;
        async_data = 32'h12345678;
        sb.push_back(async_data);
        async_req  = 1'b1;
        wait_for("bp_pvld", 1, 1'b1, n);
        repeat (10) tick();
        chk("bp_pvld_held", 32'(out_pvld), 1);
        chk("bp_pd", out_pd, 32'h12345678);
        chk("bp_ack", 32'(async_ack), 0);
        out_prdy = 1'b1;
        wait_for("bp_ack_rise", 0, 1'b1, n);
        chk("bp_ack_lat", 32'(n), 1);
        async_req = 1'b0;
        wait_for("bp_ack_fall", 0, 1'b0, n);
        chk("cnt_two", 32'(xfer_cnt), 2);

        // req held high across a reset pulse
        async_data = 32'hBAD0BAD0;
        async_req  = 1'b1;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        pv0 = pv_cnt;
        wait_for("stale_ack", 0, 1'b1, n);
        chk("stale_lat", 32'(n), SS + 1);
        chk("stale_err", 32'(err_sticky), 1);
        async_req = 1'b0;
        wait_for("stale_ack_fall", 0, 1'b0, n);
        chk("stale_nopvld", 32'(pv_cnt - pv0), 0);
        chk("stale_cnt", 32'(xfer_cnt), 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("errclr", 32'(err_sticky), 0);

        // early req drop while word is pending; set beats clear
        out_prdy   = 1'b0;
        async_data = $urandom;
        sb.push_back(async_data);
        async_req  = 1'b1;
        wait_for("early_pvld", 1, 1'b1, n);
        async_req = 1'b0;
        err_clr   = 1'b1;
        repeat (6) tick();
        chk("early_err", 32'(err_sticky), 1);
        chk("early_pvld_held", 32'(out_pvld), 1);
        err_clr  = 1'b0;
        out_prdy = 1'b1;
        wait_for("early_ack", 0, 1'b1, n);
        wait_for("early_ack_fall", 0, 1'b0, n);
        chk("early_cnt", 32'(xfer_cnt), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("early_errclr", 32'(err_sticky), 0);

        // preload counter near wrap, then random back-to-back traffic
        preload = 1'b1;
        @(posedge clk);
        force dut.cnt_q = 16'hFFFF;
        #1 preload = 1'b0;
        tick();
        release dut.cnt_q;
        chk("preload", 32'(xfer_cnt), 32'hFFFF);
        d0 = delivered;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    w = $urandom;
                    async_data = w;
                    sb.push_back(w);
                    async_req = 1'b1;
                    wait_for("b2b_ack", 0, 1'b1, n);
                    async_req  = 1'b0;
                    async_data = $urandom;
                    wait_for("b2b_ack_fall", 0, 1'b0, n);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_prdy = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        chk("wrap_cnt", 32'(xfer_cnt), 99);
        chk("b2b_delivered", 32'(delivered - d0), 100);
        chk("sb_left", 32'(sb.size()), 0);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
